mem_wb_stage: RTL

Memory-access and MEM/WB pipeline stage of the processor core; the write side of the register file.
- Takes the EX/MEM control and data, and runs loads and stores against an external data memory over a req/ready handshake.
- Freezes upstream stages while an access is outstanding.
- Registers the final wb_en / dest_wb / result_wb triple that drives the register file's write port.

---
 rtl/mem_wb_stage.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mem_wb_stage.sv
// Memory-access and MEM/WB stage: runs loads/stores against external data memory
// over a req/ready handshake, stalls upstream while busy, and drives the register-file write port.
module mem_wb_stage #(
    parameter logic [31:0] BASE_ADDR = 32'd1024,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic [3:0]        dest_in,
    input  logic [31:0]       alu_result_in,
    input  logic [31:0]       st_val_in,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              freeze,
    output logic              wb_en,
    output logic [3:0]        dest_wb,
    output logic [31:0]       result_wb
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_ACCESS   = 2'b01,
        ST_COMPLETE = 2'b10
    } state_t;

    state_t              state_q, state_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                wb_en_q, wb_en_d;
    logic [3:0]          dest_wb_q, dest_wb_d;
    logic [31:0]         result_wb_q, result_wb_d;

    logic                mem_op_s;
    logic                freeze_s;
    logic [31:0]         eff_addr_s;
    logic [ADDR_W-1:0]   addr_full_s;

    assign mem_op_s    = mem_r_en_in | mem_w_en_in;
    assign eff_addr_s  = alu_result_in - BASE_ADDR;
    assign addr_full_s = ADDR_W'(eff_addr_s);

    // Stall upstream from the first cycle a memory op is seen until its data is in hand
    always_comb begin
        freeze_s = 1'b0;
        if (state_q == ST_ACCESS) begin
            freeze_s = 1'b1;
        end else if (state_q == ST_IDLE) begin
            freeze_s = mem_op_s;
        end else begin
            freeze_s = 1'b0;
        end
    end

    // Access FSM next-state and memory-interface next values
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (mem_op_s) begin
                    state_d     = ST_ACCESS;
                    mem_req_d   = 1'b1;
                    // a simultaneous read and write resolves to a read
                    mem_we_d    = mem_w_en_in & ~mem_r_en_in;
                    mem_addr_d  = {addr_full_s[ADDR_W-1:2], 2'b00};
                    mem_wdata_d = st_val_in;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (mem_ready) begin
                    state_d   = ST_COMPLETE;
                    mem_req_d = 1'b0;
                    rdata_d   = mem_rdata;
                end else begin
                    state_d = ST_ACCESS;
                end
            end
            ST_COMPLETE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // MEM/WB register next values: bubble while frozen, otherwise take the instruction
    always_comb begin
        wb_en_d     = 1'b0;
        dest_wb_d   = dest_wb_q;
        result_wb_d = result_wb_q;
        if (freeze_s) begin
            wb_en_d = 1'b0;
        end else begin
            wb_en_d   = wb_en_in;
            dest_wb_d = dest_in;
            if (mem_r_en_in) begin
                result_wb_d = rdata_q;
            end else begin
                result_wb_d = alu_result_in;
            end
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            rdata_q     <= 32'd0;
            wb_en_q     <= 1'b0;
            dest_wb_q   <= 4'd0;
            result_wb_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            wb_en_q     <= wb_en_d;
            dest_wb_q   <= dest_wb_d;
            result_wb_q <= result_wb_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign freeze    = freeze_s;
    assign wb_en     = wb_en_q;
    assign dest_wb   = dest_wb_q;
    assign result_wb = result_wb_q;

endmodule
